// File: rtl/fifo_word_packer.sv
// Packs `ratio` narrow words from an upstream FIFO into one wide word (lane 0 = first word). The word appears on D_OUT one edge after the last DEQ.
// A single output register lets the final DEQ overlap with ENQ. With FULL_N low, DEQ stalls only once the final lane is reached.
module fifo_word_packer #(
   parameter int width = 8,
   parameter int ratio = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [width-1:0]       D_IN,
   input  logic                   EMPTY_N,
   output logic                   DEQ,
   output logic [width*ratio-1:0] D_OUT,
   output logic                   ENQ,
   input  logic                   FULL_N,
   input  logic                   CLR
);
   localparam int CW = $clog2(ratio);
   localparam int AW = (ratio - 1) * width;
   localparam logic [CW-1:0] LAST = CW'(ratio - 1);

   logic [CW-1:0]          cnt_q, cnt_d;
   logic [AW-1:0]          acc_q, acc_d;
   logic [width*ratio-1:0] out_q, out_d;
   logic                   out_vld_q, out_vld_d;
   logic                   out_free, accept, last_lane;

   always_comb begin
      ENQ       = out_vld_q & FULL_N & ~CLR & ~RST;
      out_free  = ~out_vld_q | ENQ;
      last_lane = (cnt_q == LAST);
      accept    = ~last_lane | out_free;
      DEQ       = EMPTY_N & accept & ~CLR & ~RST;
   end

   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      out_d     = out_q;
      out_vld_d = out_vld_q;
      if (ENQ) begin
         out_vld_d = 1'b0;
      end
      if (DEQ) begin
         if (last_lane) begin
            // A final-lane DEQ overrides the ENQ clear so packed words can go back to back.
            out_d     = {D_IN, acc_q};
            out_vld_d = 1'b1;
            cnt_d     = '0;
         end else begin
            for (int i = 0; i < ratio - 1; i++) begin
               if (cnt_q == CW'(i)) begin
                  acc_d[i*width +: width] = D_IN;
               end
            end
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign D_OUT = out_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed-vector bench: an 8x4 packer is driven from a table; 1x2 and 16x3 packers are streamed against an arithmetic lane model.
module tb_fifo_word_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 8-bit x 4 instance driven by the vector table
   logic        rst, clr, en, fn;
   logic [7:0]  din;
   logic        deq, enq;
   logic [31:0] dout;

   // parameter sweep instances share control, streaming continuously
   logic        rst_s;
   logic        en_s, fn_s, clr_s;
   logic [0:0]  b_din;
   logic        b_deq, b_enq;
   logic [1:0]  b_dout;
   logic [15:0] c_din;
   logic        c_deq, c_enq;
   logic [47:0] c_dout;

   fifo_word_packer #(.width(8), .ratio(4)) dut (
      .CLK(clk), .RST(rst), .D_IN(din), .EMPTY_N(en), .DEQ(deq),
      .D_OUT(dout), .ENQ(enq), .FULL_N(fn), .CLR(clr)
   );

   fifo_word_packer #(.width(1), .ratio(2)) dut_b (
      .CLK(clk), .RST(rst_s), .D_IN(b_din), .EMPTY_N(en_s), .DEQ(b_deq),
      .D_OUT(b_dout), .ENQ(b_enq), .FULL_N(fn_s), .CLR(clr_s)
   );

   fifo_word_packer #(.width(16), .ratio(3)) dut_c (
      .CLK(clk), .RST(rst_s), .D_IN(c_din), .EMPTY_N(en_s), .DEQ(c_deq),
      .D_OUT(c_dout), .ENQ(c_enq), .FULL_N(fn_s), .CLR(clr_s)
   );

   typedef struct {
      logic        rst;
      logic        clr;
      logic        en;
      logic        fn;
      logic [7:0]  din;
      logic        deq;
      logic        enq;
      logic [31:0] dout;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   function automatic void add(logic r, logic c, logic e, logic f, logic [7:0] d,
                               logic xdeq, logic xenq, logic [31:0] xdout);
      vec_t v;
      v.rst = r; v.clr = c; v.en = e; v.fn = f; v.din = d;
      v.deq = xdeq; v.enq = xenq; v.dout = xdout;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int step, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
      end
   endtask

   function automatic logic word_b(int j);
      logic [15:0] pat;
      pat = 16'hB2C5;
      return pat[j % 16];
   endfunction

   function automatic logic [15:0] word_c(int j);
      return 16'(16'hA000 + j * 273);
   endfunction

   function automatic logic [1:0] exp_b(int j);
      int k;
      k = j / 2;
      if (k == 0) return 2'b00;
      return {word_b((k - 1) * 2 + 1), word_b((k - 1) * 2)};
   endfunction

   function automatic logic [47:0] exp_c(int j);
      int k;
      k = j / 3;
      if (k == 0) return 48'h0;
      return {word_c((k - 1) * 3 + 2), word_c((k - 1) * 3 + 1), word_c((k - 1) * 3)};
   endfunction

   initial begin
      rst = 1'b1; clr = 1'b0; en = 1'b0; fn = 1'b0; din = 8'h00;
      rst_s = 1'b1; en_s = 1'b1; fn_s = 1'b1; clr_s = 1'b0;
      b_din = 1'b0; c_din = 16'h0;

      //   rst clr en fn din    deq enq dout
      add(1, 0, 1, 1, 8'h00, 0, 0, 32'h0);
      // streaming
      add(0, 0, 1, 1, 8'h11, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h22, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h33, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h44, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h55, 1, 1, 32'h44332211);
      add(0, 0, 1, 1, 8'h66, 1, 0, 32'h44332211);
      add(0, 0, 1, 1, 8'h77, 1, 0, 32'h44332211);
      add(0, 0, 1, 1, 8'h88, 1, 0, 32'h44332211);
      add(0, 0, 0, 1, 8'h00, 0, 1, 32'h88776655);
      add(0, 0, 0, 1, 8'h00, 0, 0, 32'h88776655);
      // downstream back-pressure, then release
      add(0, 0, 1, 0, 8'h11, 1, 0, 32'h88776655);
      add(0, 0, 1, 0, 8'h22, 1, 0, 32'h88776655);
      add(0, 0, 1, 0, 8'h33, 1, 0, 32'h88776655);
      add(0, 0, 1, 0, 8'h44, 1, 0, 32'h88776655);
      add(0, 0, 1, 0, 8'h55, 1, 0, 32'h44332211);
      add(0, 0, 1, 0, 8'h66, 1, 0, 32'h44332211);
      add(0, 0, 1, 0, 8'h77, 1, 0, 32'h44332211);
      add(0, 0, 1, 0, 8'h88, 0, 0, 32'h44332211);
      add(0, 0, 1, 0, 8'h88, 0, 0, 32'h44332211);
      add(0, 0, 1, 1, 8'h88, 1, 1, 32'h44332211);
      add(0, 0, 0, 1, 8'h00, 0, 1, 32'h88776655);
      // upstream bubbles 1,0,0,1,1,0,1
      add(0, 0, 1, 1, 8'hA1, 1, 0, 32'h88776655);
      add(0, 0, 0, 1, 8'hA2, 0, 0, 32'h88776655);
      add(0, 0, 0, 1, 8'hA2, 0, 0, 32'h88776655);
      add(0, 0, 1, 1, 8'hA2, 1, 0, 32'h88776655);
      add(0, 0, 1, 1, 8'hA3, 1, 0, 32'h88776655);
      add(0, 0, 0, 1, 8'hA4, 0, 0, 32'h88776655);
      add(0, 0, 1, 1, 8'hA4, 1, 0, 32'h88776655);
      add(0, 0, 0, 1, 8'h00, 0, 1, 32'hA4A3A2A1);
      // CLR after two lanes
      add(0, 0, 1, 1, 8'hAA, 1, 0, 32'hA4A3A2A1);
      add(0, 0, 1, 1, 8'hBB, 1, 0, 32'hA4A3A2A1);
      add(0, 1, 1, 1, 8'hCC, 0, 0, 32'hA4A3A2A1);
      add(0, 0, 1, 1, 8'h01, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h02, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h03, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h04, 1, 0, 32'h0);
      add(0, 0, 0, 1, 8'h00, 0, 1, 32'h04030201);
      // reset with a pending output and a partial word
      add(0, 0, 1, 0, 8'h10, 1, 0, 32'h04030201);
      add(0, 0, 1, 0, 8'h20, 1, 0, 32'h04030201);
      add(0, 0, 1, 0, 8'h30, 1, 0, 32'h04030201);
      add(0, 0, 1, 0, 8'h40, 1, 0, 32'h04030201);
      add(0, 0, 1, 0, 8'h50, 1, 0, 32'h40302010);
      add(1, 0, 1, 1, 8'h60, 0, 0, 32'h40302010);
      add(0, 0, 0, 1, 8'h00, 0, 0, 32'h0);
      add(0, 0, 1, 1, 8'h0D, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h0C, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h0B, 1, 0, 32'h0);
      add(0, 0, 1, 1, 8'h0A, 1, 0, 32'h0);
      add(0, 0, 0, 1, 8'h00, 0, 1, 32'h0A0B0C0D);
      add(0, 0, 0, 1, 8'h00, 0, 0, 32'h0A0B0C0D);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; clr = vecs[i].clr; en = vecs[i].en;
         fn  = vecs[i].fn;  din = vecs[i].din;
         @(negedge clk);
         check("deq", i, 64'(deq), 64'(vecs[i].deq));
         check("enq", i, 64'(enq), 64'(vecs[i].enq));
         check("dout", i, 64'(dout), 64'(vecs[i].dout));
         @(posedge clk);
         #1;
      end

      // parameter sweep: continuous streaming out of reset
      rst = 1'b1;
      rst_s = 1'b0;
      for (int j = 0; j < 13; j++) begin
         b_din = word_b(j);
         c_din = word_c(j);
         @(negedge clk);
         check("b_deq", j, 64'(b_deq), 64'(1));
         check("b_enq", j, 64'(b_enq), 64'((j >= 2) && (j % 2 == 0)));
         check("b_dout", j, 64'(b_dout), 64'(exp_b(j)));
         check("c_deq", j, 64'(c_deq), 64'(1));
         check("c_enq", j, 64'(c_enq), 64'((j >= 3) && (j % 3 == 0)));
         check("c_dout", j, 64'(c_dout), 64'(exp_c(j)));
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
